// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell reused across WIDTH bits, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             sum_bit;
    logic             carry_next;

    // The single shared full-adder cell.
    assign sum_bit    = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    psum  <= {sum_bit, psum[WIDTH-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= carry_next;
                    if (cnt == LAST) begin
                        // Final bit: publish the completed word, never the partial one.
                        sum   <= {sum_bit, psum[WIDTH-1:1]};
                        cout  <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= carry ^ carry_next;
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic reference.
// Also checks ovf when built with SERIAL_ADDER_OVF_EN.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests = 0;
    int fails = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request at the current falling edge; it is accepted at the next rising edge,
    // then operands are scrambled every cycle. poke>=0 raises start during that RUN cycle.
    task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                          input int poke);
        logic [W:0] full;
        int         sgn;
        full = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, ci};
        sgn  = int'($signed(ai)) + int'($signed(bi)) + int'(ci);
        a = ai; b = bi; cin = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_ready", ready, 0);
        for (int k = 1; k < W; k++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            start = (k == poke);
            @(negedge clk);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_sum_hold", sum, last_sum);
        end
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_ready", ready, 1);
        chk("sum", sum, full[W-1:0]);
        chk("cout", cout, full[W]);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, (sgn > 127 || sgn < -128) ? 1 : 0);
`endif
        last_sum  = full[W-1:0];
        last_cout = full[W];
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", ready, 1);
        chk("idle_sum_hold", sum, last_sum);
        chk("idle_cout_hold", cout, last_cout);
    endtask

    initial begin
        // Reset held for two edges with a pending request.
        rst_n = 1'b0; start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst_n = 1'b1; start = 1'b0;
        last_sum = '0; last_cout = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_idle_busy", busy, 0);

        // Directed cases.
        run_op(8'h35, 8'h4A, 1'b0, -1);
        idle_check();
        run_op(8'hFF, 8'h01, 1'b0, -1);
        idle_check();
        run_op(8'hFF, 8'hFF, 1'b1, -1);
        idle_check();
        run_op(8'h10, 8'h20, 1'b0, 3);
        idle_check();
        idle_check();

        // Abandon an operation mid-run.
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        last_sum = '0; last_cout = 1'b0;
        for (int k = 0; k < W + 1; k++) begin
            @(negedge clk);
            chk("midrst_no_done", done, 0);
        end
        run_op(8'h02, 8'h03, 1'b1, -1);

        // Back-to-back: the next request is driven during the DONE cycle.
        run_op(8'h7F, 8'h01, 1'b0, -1);
        run_op(8'h80, 8'h80, 1'b0, -1);
        idle_check();

        // Randomized operations, randomly back-to-back.
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W - 1)) : -1);
            if ($urandom_range(0, 1) == 0) idle_check();
        end
        idle_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
